// File: rtl/uart_reg_arbiter_if.sv
// Register-port bundle shared by the two requesters, the arbiter and the UART core.
// Handshake: reqN is a level held with rwN/addrN/wdataN stable until the one-cycle
// ackN. These inputs are sampled only while the arbiter is idle. rdata is valid while
// ack0|ack1 is high.
interface uart_reg_arbiter_if #(
  parameter int B = 7,
  parameter int A = 2
);
  logic       req0, req1;
  logic       rw0, rw1;
  logic [A:0] addr0, addr1;
  logic [B:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [B:0] rdata;
  logic       busy;
  logic       gnt_id;
  logic       uart_cs;
  logic       uart_nrw;
  logic [A:0] uart_add;
  logic [B:0] uart_din;
  logic [B:0] uart_dout;
  logic [1:0] dbg_state;

  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, uart_dout,
    output ack0, ack1, rdata, busy, gnt_id, uart_cs, uart_nrw, uart_add, uart_din,
           dbg_state
  );

  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, uart_dout,
    input  ack0, ack1, rdata, busy, gnt_id, uart_cs, uart_nrw, uart_add, uart_din,
           dbg_state
  );
endinterface

// File: rtl/uart_reg_arbiter.sv
// Round-robin arbiter sharing the UART register port between the CPU bridge (port 0)
// and the TX/RX pump (port 1); one access in flight, all UART-side outputs registered.
module uart_reg_arbiter #(
  parameter int B      = 7,
  parameter int A      = 2,
  parameter int RD_LAT = 1
) (
  input logic              clk,
  input logic              reset,
  uart_reg_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_rd_lat_check
    $error("uart_reg_arbiter: RD_LAT must be in 1..15");
  end

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       gnt_q, gnt_d;
  logic       rw_q, rw_d;
  logic       cs_q, cs_d;
  logic       nrw_q, nrw_d;
  logic [A:0] add_q, add_d;
  logic [B:0] din_q, din_d;
  logic [B:0] rdata_q, rdata_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       win;
  logic       win_rw;

  always_comb begin
    // On a tie the port that did not win last time gets the grant.
    win     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    win_rw  = win ? bus.rw1 : bus.rw0;
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    rw_d    = rw_q;
    cs_d    = cs_q;
    nrw_d   = nrw_q;
    add_d   = add_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_d   = win;
          last_d  = win;
          rw_d    = win_rw;
          add_d   = win ? bus.addr1 : bus.addr0;
          din_d   = win ? bus.wdata1 : bus.wdata0;
          cs_d    = 1'b1;
          nrw_d   = win_rw;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        nrw_d   = 1'b0;
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (!rw_q) begin
            rdata_d = bus.uart_dout;
          end
          cs_d    = 1'b0;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      rw_q    <= 1'b0;
      cs_q    <= 1'b0;
      nrw_q   <= 1'b0;
      add_q   <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      rw_q    <= rw_d;
      cs_q    <= cs_d;
      nrw_q   <= nrw_d;
      add_q   <= add_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.gnt_id    = gnt_q;
  assign bus.uart_cs   = cs_q;
  assign bus.uart_nrw  = nrw_q;
  assign bus.uart_add  = add_q;
  assign bus.uart_din  = din_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_uart_reg_arbiter.sv
// Bench for uart_reg_arbiter: two instances (RD_LAT=1 and RD_LAT=4) checked every cycle
// against a timing model of accesses, plus directed scenarios with literal expectations.
module tb_uart_reg_arbiter;
  localparam int B = 7;
  localparam int A = 2;
  localparam int RANDOM_CYCLES = 3000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  uart_reg_arbiter_if #(.B(B), .A(A)) bus_a ();
  uart_reg_arbiter_if #(.B(B), .A(A)) bus_b ();

  uart_reg_arbiter #(.B(B), .A(A), .RD_LAT(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  uart_reg_arbiter #(.B(B), .A(A), .RD_LAT(4)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  // Index [d] selects instance (0: RD_LAT=1, 1: RD_LAT=4), [p] selects requester port.
  logic       req_v [2][2];
  logic       rw_v  [2][2];
  logic [A:0] addr_v [2][2];
  logic [B:0] wdata_v [2][2];
  logic [B:0] dout_v [2];
  logic       ack_v [2][2];
  logic       busy_v [2], gnt_v [2], cs_v [2], nrw_v [2];
  logic [A:0] add_v [2];
  logic [B:0] din_v [2], rdata_v [2];
  string      dn [2] = '{"lat1", "lat4"};

  assign bus_a.req0 = req_v[0][0];     assign bus_a.req1 = req_v[0][1];
  assign bus_a.rw0 = rw_v[0][0];       assign bus_a.rw1 = rw_v[0][1];
  assign bus_a.addr0 = addr_v[0][0];   assign bus_a.addr1 = addr_v[0][1];
  assign bus_a.wdata0 = wdata_v[0][0]; assign bus_a.wdata1 = wdata_v[0][1];
  assign bus_a.uart_dout = dout_v[0];
  assign bus_b.req0 = req_v[1][0];     assign bus_b.req1 = req_v[1][1];
  assign bus_b.rw0 = rw_v[1][0];       assign bus_b.rw1 = rw_v[1][1];
  assign bus_b.addr0 = addr_v[1][0];   assign bus_b.addr1 = addr_v[1][1];
  assign bus_b.wdata0 = wdata_v[1][0]; assign bus_b.wdata1 = wdata_v[1][1];
  assign bus_b.uart_dout = dout_v[1];

  assign ack_v[0][0] = bus_a.ack0;   assign ack_v[0][1] = bus_a.ack1;
  assign busy_v[0] = bus_a.busy;     assign gnt_v[0] = bus_a.gnt_id;
  assign cs_v[0] = bus_a.uart_cs;    assign nrw_v[0] = bus_a.uart_nrw;
  assign add_v[0] = bus_a.uart_add;  assign din_v[0] = bus_a.uart_din;
  assign rdata_v[0] = bus_a.rdata;
  assign ack_v[1][0] = bus_b.ack0;   assign ack_v[1][1] = bus_b.ack1;
  assign busy_v[1] = bus_b.busy;     assign gnt_v[1] = bus_b.gnt_id;
  assign cs_v[1] = bus_b.uart_cs;    assign nrw_v[1] = bus_b.uart_nrw;
  assign add_v[1] = bus_b.uart_add;  assign din_v[1] = bus_b.uart_din;
  assign rdata_v[1] = bus_b.rdata;

  // ---------------- reference model ----------------
  // An access granted at the end of cycle c issues in c+1, holds the UART port through
  // c+1+RD_LAT and acks in c+2+RD_LAT; the arbiter samples again from c+3+RD_LAT.
  bit         m_act [2], m_port [2], m_rw [2], m_last [2], m_gnt [2], m_w;
  logic [A:0] m_addr [2];
  logic [B:0] m_wdata [2], m_rdata [2];
  int         m_issue [2], m_ack [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        m_act[d] = 1'b0; m_last[d] = 1'b1; m_gnt[d] = 1'b0; m_rdata[d] = '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_act[d]) begin
          if (cyc == m_ack[d] - 1 && !m_rw[d]) m_rdata[d] = dout_v[d];
          if (cyc == m_ack[d]) m_act[d] = 1'b0;
        end else if (req_v[d][0] || req_v[d][1]) begin
          m_w        = (req_v[d][0] && req_v[d][1]) ? !m_last[d] : req_v[d][1];
          m_act[d]   = 1'b1;
          m_port[d]  = m_w;
          m_rw[d]    = rw_v[d][m_w];
          m_addr[d]  = addr_v[d][m_w];
          m_wdata[d] = wdata_v[d][m_w];
          m_issue[d] = cyc + 1;
          m_ack[d]   = cyc + 2 + lat_of(d);
          m_last[d]  = m_w;
          m_gnt[d]   = m_w;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    for (int d = 0; d < 2; d++) begin
      bit act  = m_act[d];
      bit cs_e = act && (cyc < m_ack[d]);
      check({dn[d], ".busy"}, busy_v[d], act);
      check({dn[d], ".cs"}, cs_v[d], cs_e);
      check({dn[d], ".nrw"}, nrw_v[d], act && cyc == m_issue[d] && m_rw[d]);
      check({dn[d], ".ack0"}, ack_v[d][0], act && cyc == m_ack[d] && !m_port[d]);
      check({dn[d], ".ack1"}, ack_v[d][1], act && cyc == m_ack[d] && m_port[d]);
      check({dn[d], ".rdata"}, rdata_v[d], m_rdata[d]);
      check({dn[d], ".gnt_id"}, gnt_v[d], m_gnt[d]);
      if (cs_e) check({dn[d], ".add"}, add_v[d], m_addr[d]);
      if (act && cyc == m_issue[d]) check({dn[d], ".din"}, din_v[d], m_wdata[d]);
    end
  endtask

  // ---------------- driver tasks ----------------
  int p_req    = 0;
  bit renew_en = 1'b1;

  function automatic logic [B:0] rnd_data();
    logic [31:0] r;
    r = $urandom;
    return r[B:0];
  endfunction

  function automatic logic [A:0] rnd_addr();
    logic [31:0] r;
    r = $urandom;
    return r[A:0];
  endfunction

  task automatic new_payload(input int d, input int p);
    req_v[d][p]   = 1'b1;
    rw_v[d][p]    = 1'($urandom_range(0, 1));
    addr_v[d][p]  = rnd_addr();
    wdata_v[d][p] = rnd_data();
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      dout_v[d] = '0;
      for (int p = 0; p < 2; p++) begin
        req_v[d][p] = 1'b0; rw_v[d][p] = 1'b0; addr_v[d][p] = '0; wdata_v[d][p] = '0;
      end
    end
  endtask

  task automatic drive_random();
    for (int d = 0; d < 2; d++) begin
      dout_v[d] = rnd_data();
      for (int p = 0; p < 2; p++) begin
        bit owned = m_act[d] && (int'(m_port[d]) == p);
        if (owned && cyc == m_ack[d]) begin
          if (renew_en && $urandom_range(0, 3) == 0) new_payload(d, p);
          else req_v[d][p] = 1'b0;
        end else if (owned) begin
          // Inputs wiggled mid-access must not reach the UART port.
          if ($urandom_range(0, 3) == 0) begin
            rw_v[d][p] = 1'($urandom_range(0, 1));
            addr_v[d][p] = rnd_addr();
            wdata_v[d][p] = rnd_data();
          end
        end else if (req_v[d][p]) begin
          if ($urandom_range(0, 15) == 0) req_v[d][p] = 1'b0;
        end else if ($urandom_range(0, 7) < p_req) begin
          new_payload(d, p);
        end
      end
    end
  endtask

  task automatic step(input bit auto_drive);
    @(negedge clk);
    check_cycle();
    if (auto_drive) drive_random();
  endtask

  // ---------------- main sequence ----------------
  logic exp_q [$];
  int   n_acks;
  int   budget;

  initial begin
    clear_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check({dn[d], ".rst_busy"}, busy_v[d], 1'b0);
      check({dn[d], ".rst_cs"}, cs_v[d], 1'b0);
      check({dn[d], ".rst_nrw"}, nrw_v[d], 1'b0);
      check({dn[d], ".rst_ack"}, {ack_v[d][1], ack_v[d][0]}, 2'b00);
      check({dn[d], ".rst_add"}, add_v[d], '0);
      check({dn[d], ".rst_din"}, din_v[d], '0);
      check({dn[d], ".rst_rdata"}, rdata_v[d], '0);
      check({dn[d], ".rst_gnt"}, gnt_v[d], 1'b0);
    end
    reset = 1'b1;
    step(0);

    // Port 0 write on RD_LAT=1: ISSUE shows the strobe, ack0 at T+3, rdata untouched.
    req_v[0][0] = 1'b1; rw_v[0][0] = 1'b1; addr_v[0][0] = 3'd3; wdata_v[0][0] = 8'hA5;
    step(0);
    check("wr.issue_cs", cs_v[0], 1'b1);
    check("wr.issue_nrw", nrw_v[0], 1'b1);
    check("wr.issue_add", add_v[0], 3'd3);
    check("wr.issue_din", din_v[0], 8'hA5);
    step(0);
    check("wr.wait_nrw", nrw_v[0], 1'b0);
    check("wr.wait_ack0", ack_v[0][0], 1'b0);
    step(0);
    check("wr.ack0", ack_v[0][0], 1'b1);
    check("wr.rdata_kept", rdata_v[0], 8'h00);
    req_v[0][0] = 1'b0;
    step(0);

    // Port 1 read on RD_LAT=1 returning 0x5C.
    req_v[0][1] = 1'b1; rw_v[0][1] = 1'b0; addr_v[0][1] = 3'd1;
    step(0);
    check("rd.issue_add", add_v[0], 3'd1);
    check("rd.issue_nrw", nrw_v[0], 1'b0);
    dout_v[0] = 8'h5C;
    step(0);
    step(0);
    check("rd.ack1", ack_v[0][1], 1'b1);
    check("rd.ack0_quiet", ack_v[0][0], 1'b0);
    check("rd.rdata", rdata_v[0], 8'h5C);
    check("rd.gnt_id", gnt_v[0], 1'b1);
    req_v[0][1] = 1'b0; dout_v[0] = '0;
    step(0);

    // RD_LAT=4 read: four WAIT cycles, address held while addr0 moves, data from last WAIT.
    req_v[1][0] = 1'b1; rw_v[1][0] = 1'b0; addr_v[1][0] = 3'd6;
    step(0);
    check("lat4.issue_cs", cs_v[1], 1'b1);
    addr_v[1][0] = 3'd1;
    for (int i = 0; i < 4; i++) begin
      step(0);
      check("lat4.wait_cs", cs_v[1], 1'b1);
      check("lat4.wait_nrw", nrw_v[1], 1'b0);
      check("lat4.wait_add", add_v[1], 3'd6);
      check("lat4.wait_ack0", ack_v[1][0], 1'b0);
      addr_v[1][0] = rnd_addr();
      dout_v[1] = 8'h30 + 8'(i);
    end
    step(0);
    check("lat4.ack0", ack_v[1][0], 1'b1);
    check("lat4.done_cs", cs_v[1], 1'b0);
    check("lat4.rdata", rdata_v[1], 8'h33);
    req_v[1][0] = 1'b0;
    step(0);

    // Reset asserted in the middle of a RD_LAT=4 WAIT.
    req_v[1][1] = 1'b1; rw_v[1][1] = 1'b0; addr_v[1][1] = 3'd2;
    step(0);
    step(0);
    check("abort.pre_cs", cs_v[1], 1'b1);
    #2 reset = 1'b0;
    #1;
    check("abort.cs", cs_v[1], 1'b0);
    check("abort.acks", {ack_v[1][1], ack_v[1][0]}, 2'b00);
    check("abort.busy", busy_v[1], 1'b0);
    clear_inputs();
    step(0);
    step(0);
    reset = 1'b1;

    // Both ports held high: grants alternate starting with port 0.
    for (int d = 0; d < 2; d++) begin
      new_payload(d, 0);
      new_payload(d, 1);
    end
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    n_acks = 0;
    budget = 0;
    while (exp_q.size() > 0 && budget < 60) begin
      step(0);
      budget++;
      if (ack_v[0][0] || ack_v[0][1]) begin
        logic e;
        e = exp_q.pop_front();
        check("fair.both_acks", ack_v[0][0] & ack_v[0][1], 1'b0);
        check("fair.ack_port", ack_v[0][1], e);
        check("fair.gnt_id", gnt_v[0], e);
        n_acks++;
      end
    end
    check("fair.ack_count", n_acks, 6);
    clear_inputs();

    // Randomized traffic with withdrawals, mid-access input changes and one reset pulse.
    p_req = 3;
    for (int i = 0; i < RANDOM_CYCLES; i++) begin
      step(1);
      if (i == RANDOM_CYCLES / 2) begin
        #2 reset = 1'b0;
        step(1);
        step(1);
        reset = 1'b1;
      end
    end

    p_req = 0;
    renew_en = 1'b0;
    budget = 0;
    while ((m_act[0] || m_act[1] || req_v[0][0] || req_v[0][1] || req_v[1][0] || req_v[1][1])
           && budget < 200) begin
      step(1);
      budget++;
    end
    check("drain.idle", busy_v[0] | busy_v[1], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
